// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier: one multiplier bit per clock, result + wrEn strobe WIDTH+1 edges after accept.
// No backpressure: start is taken only when ready, requests during RUN/DONE are dropped.
module seq_multiplier #(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] dataOut,
   output logic             overflow,
   output logic             wrEn
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               ovf_q, ovf_d;
   logic               wren_q, wren_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         wren_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         wren_q   <= wren_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      ovf_d    = ovf_q;
      wren_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // Multiplicand walks left while the multiplier walks right, so bit 0 is always the current bit.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            dout_d  = acc_q[WIDTH-1:0];
            ovf_d   = |acc_q[2*WIDTH-1:WIDTH];
            wren_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ready    = (state_q == IDLE);
   assign busy     = ~ready;
   assign dataOut  = dout_q;
   assign overflow = ovf_q;
   assign wrEn     = wren_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier (WIDTH=12): directed cases plus random operands against a plain-arithmetic product model.
module tb_seq_multiplier;

   localparam int W   = 12;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ready;
   logic         busy;
   logic [W-1:0] dataOut;
   logic         overflow;
   logic         wrEn;

   int total = 0;
   int bad   = 0;
   int strobes = 0;
   logic [W-1:0] dreg;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .dataOut  (dataOut),
      .overflow (overflow),
      .wrEn     (wrEn)
   );

   always #5 clk = ~clk;

   // Downstream datapath register the multiplier feeds directly.
   always @(posedge clk) begin
      if (wrEn === 1'b1) dreg <= dataOut;
   end

   always @(negedge clk) begin
      if (wrEn === 1'b1) strobes <= strobes + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the strobe after an accept edge; k is edges counted from the accept edge.
   task automatic wait_strobe(input int inj, output int k);
      bit seen;
      seen = 0;
      k = 0;
      while (!seen && k < 40) begin
         tick();
         k++;
         if (wrEn === 1'b1) begin
            seen = 1;
         end else begin
            chk("busy_in_op", 32'({ready, busy}), 32'b01);
            if (k == inj) begin
               start = 1'b1;
               a = 12'd1;
               b = 12'd1;
            end
            if (k == inj + 1) start = 1'b0;
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int inj);
      logic [2*W-1:0] prod;
      logic [W-1:0]   ed;
      logic           eo;
      int             k;
      int             s0;
      prod = (2*W)'(ta) * (2*W)'(tbv);
      ed = prod[W-1:0];
      eo = (prod >> W) != 0;
      chk("ready_before", 32'(ready), 32'd1);
      s0 = strobes;
      a = ta;
      b = tbv;
      start = 1'b1;
      tick();
      start = 1'b0;
      a = 12'($urandom);
      b = 12'($urandom);
      wait_strobe(inj, k);
      chk("latency", 32'(k), 32'(LAT));
      chk("dataOut", 32'(dataOut), 32'(ed));
      chk("overflow", 32'(overflow), 32'(eo));
      chk("ready_at_strobe", 32'({ready, busy}), 32'b10);
      tick();
      chk("wrEn_one_cycle", 32'(wrEn), 32'd0);
      chk("dataOut_held", 32'(dataOut), 32'(ed));
      chk("reg_captured", 32'(dreg), 32'(ed));
      chk("strobe_count", 32'(strobes - s0), 32'd1);
   endtask

   initial begin
      int k;
      int s0;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      #1;
      chk("reset_ready", 32'({ready, busy}), 32'b10);
      chk("reset_dataOut", 32'(dataOut), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_wrEn", 32'(wrEn), 32'd0);
      tick();
      rst = 1'b0;

      run_op(12'd3, 12'd5, -1);
      run_op(12'd4095, 12'd4095, -1);
      run_op(12'd64, 12'd64, -1);
      run_op(12'd0, 12'd2748, -1);

      // Start pulsed mid-operation must be dropped.
      s0 = strobes;
      run_op(12'd7, 12'd9, 5);
      repeat (20) tick();
      chk("ignored_start_no_strobe", 32'(strobes - s0), 32'd1);

      // Asynchronous reset mid-operation.
      a = 12'd100;
      b = 12'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      s0 = strobes;
      rst = 1'b1;
      #1;
      chk("abort_dataOut", 32'(dataOut), 32'd0);
      chk("abort_overflow", 32'(overflow), 32'd0);
      chk("abort_ready", 32'({ready, busy}), 32'b10);
      tick();
      rst = 1'b0;
      repeat (20) tick();
      chk("abort_no_strobe", 32'(strobes - s0), 32'd0);
      run_op(12'd10, 12'd10, -1);

      // Back-to-back with start held high.
      a = 12'd2;
      b = 12'd3;
      start = 1'b1;
      tick();
      a = 12'd11;
      b = 12'd11;
      wait_strobe(-5, k);
      chk("b2b_lat1", 32'(k), 32'(LAT));
      chk("b2b_data1", 32'(dataOut), 32'(2 * 3));
      tick();
      start = 1'b0;
      chk("b2b_accept2", 32'(busy), 32'd1);
      chk("b2b_reg1", 32'(dreg), 32'(2 * 3));
      wait_strobe(-5, k);
      chk("b2b_spacing", 32'(k + 1), 32'(W + 2));
      chk("b2b_reg_hold", 32'(dreg), 32'(2 * 3));
      chk("b2b_data2", 32'(dataOut), 32'(11 * 11));
      tick();
      chk("b2b_reg2", 32'(dreg), 32'(11 * 11));

      for (int i = 0; i < 24; i++) begin
         ra = 12'($urandom_range(4095, 0));
         rb = 12'($urandom_range(4095, 0));
         if (i % 8 == 3) ra = 12'd4095;
         if (i % 8 == 5) rb = 12'd0;
         repeat ($urandom_range(2, 0)) tick();
         run_op(ra, rb, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
